// File: rtl/mfcc_fp_pkg.sv
`default_nettype none
// ============================================================================
//  Package   : mfcc_fp_pkg
//  Purpose   : IEEE-754 single-precision field constants and a packing helper
//              shared by the MFCC floating-point datapath blocks.
//  Revision  : 1.0 - initial release
// ============================================================================
package mfcc_fp_pkg;

  localparam int          FP32_EXP_BIAS = 127;
  localparam int          FP32_MANT_W   = 23;
  localparam int          FP32_EXP_W    = 8;
  localparam logic [31:0] FP32_ZERO     = 32'h0000_0000;

  // Assemble a float32 word from its sign, biased exponent and fraction fields.
  function automatic logic [31:0] fp32_pack(input logic                   sign,
                                            input logic [FP32_EXP_W-1:0]  exp_f,
                                            input logic [FP32_MANT_W-1:0] mant_f);
    return {sign, exp_f, mant_f};
  endfunction

endpackage
`default_nettype wire

// File: rtl/exp_to_float_pipe_if.sv
`default_nettype none
// ============================================================================
//  Interface : exp_to_float_pipe_if
//  Purpose   : Valid/ready input stream (biased exponent) and output stream
//              (float32 word) of the exponent-to-float converter.
//  Revision  : 1.0 - initial release
// ============================================================================
interface exp_to_float_pipe_if #(
  parameter int EXP_W = 8
) ();

  logic             in_valid;
  logic             in_ready;
  logic [EXP_W-1:0] exp_in;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_data;

  // Producer / consumer side that talks to the converter.
  modport master (
    output in_valid, exp_in, out_ready,
    input  in_ready, out_valid, out_data
  );

  // Converter side.
  modport slave (
    input  in_valid, exp_in, out_ready,
    output in_ready, out_valid, out_data
  );

endinterface
`default_nettype wire

// File: rtl/lod_u.sv
`default_nettype none
// ============================================================================
//  Module    : lod_u
//  Purpose   : Combinational leading-one detector. Reports the index of the
//              most significant set bit of vec and whether any bit is set.
//  Revision  : 1.0 - initial release
// ============================================================================
module lod_u #(
  parameter int W     = 8,
  parameter int POS_W = (W > 1) ? $clog2(W) : 1
) (
  input  wire logic [W-1:0]     vec,
  output logic      [POS_W-1:0] pos,
  output logic                  found
);

  // Scan upward so the highest set bit is the last one to overwrite pos.
  always_comb begin
    pos   = '0;
    found = 1'b0;
    for (int i = 0; i < W; i++) begin
      if (vec[i]) begin
        pos   = POS_W'(i);
        found = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/exp_to_float_pipe.sv
`default_nettype none
// ============================================================================
//  Module    : exp_to_float_pipe
//  Purpose   : Two-stage valid/ready pipeline converting a biased exponent
//              field into the float32 value (exp_in - BIAS).
//              S1: signed subtract, magnitude and zero detection.
//              S2: leading-one normalisation and float32 packing.
//  Revision  : 1.0 - initial release
// ============================================================================
module exp_to_float_pipe
  import mfcc_fp_pkg::*;
#(
  parameter int EXP_W     = 8,
  parameter int BIAS      = 127,
  parameter int ZERO_EDGE = 1
) (
  input wire logic            clk,
  input wire logic            rst,
  exp_to_float_pipe_if.slave  bus
);

  localparam int               POS_W    = (EXP_W > 1) ? $clog2(EXP_W) : 1;
  localparam logic [EXP_W:0]   BIAS_EXT = (EXP_W+1)'(BIAS);
  localparam logic [4:0]       MANT_SH  = 5'(FP32_MANT_W);

  // Handshake
  logic                    w_s2_can_load;
  logic                    w_in_ready;

  // Stage 1 combinational inputs and registers
  logic signed [EXP_W:0]   w_d;
  logic [EXP_W-1:0]        w_mag;
  logic                    w_zero;
  logic                    r_s1_valid;
  logic                    r_s1_sign;
  logic                    r_s1_zero;
  logic [EXP_W-1:0]        r_s1_mag;

  // Stage 2 combinational inputs and registers
  logic [POS_W-1:0]        w_pos;
  logic                    w_found;
  logic [FP32_EXP_W-1:0]   w_exp8;
  logic [FP32_MANT_W-1:0]  w_mant;
  logic [31:0]             w_s2_next;
  logic                    r_s2_valid;
  logic [31:0]             r_s2_data;

  // A stage may load when empty or when its content leaves this same cycle.
  always_comb begin
    w_s2_can_load = !r_s2_valid || bus.out_ready;
    w_in_ready    = !r_s1_valid || w_s2_can_load;
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_s2_valid;
  assign bus.out_data  = r_s2_data;

  // S1 arithmetic: |exp_in - BIAS|, its sign, and the forced-zero condition.
  always_comb begin
    w_d   = $signed({1'b0, bus.exp_in}) - $signed(BIAS_EXT);
    w_mag = w_d[EXP_W] ? EXP_W'(-w_d) : w_d[EXP_W-1:0];
    w_zero = (w_d == '0) ||
             ((ZERO_EDGE != 0) && ((bus.exp_in == '0) || (bus.exp_in == '1)));
  end

  // Stage 1 register: valid bit plus sign/magnitude/zero payload.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_sign  <= 1'b0;
      r_s1_zero  <= 1'b0;
      r_s1_mag   <= '0;
    end else if (w_in_ready) begin
      r_s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        r_s1_sign <= w_d[EXP_W];
        r_s1_zero <= w_zero;
        r_s1_mag  <= w_mag;
      end
    end
  end

  lod_u #(
    .W     (EXP_W),
    .POS_W (POS_W)
  ) u_lod (
    .vec   (r_s1_mag),
    .pos   (w_pos),
    .found (w_found)
  );

  // S2 arithmetic: exponent from the leading-one index, fraction from the bits
  // below it shifted up so the leading one lands just above bit 22 and drops off.
  always_comb begin
    w_exp8 = FP32_EXP_W'(FP32_EXP_BIAS) + FP32_EXP_W'(w_pos);
    w_mant = FP32_MANT_W'({{FP32_MANT_W{1'b0}}, r_s1_mag} << (MANT_SH - 5'(w_pos)));
    if (r_s1_zero || !w_found) begin
      w_s2_next = FP32_ZERO;
    end else begin
      w_s2_next = fp32_pack(r_s1_sign, w_exp8, w_mant);
    end
  end

  // Stage 2 register: drives the output and holds it while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s2_valid <= 1'b0;
      r_s2_data  <= '0;
    end else if (w_s2_can_load) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_data <= w_s2_next;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_exp_to_float_pipe.sv
`default_nettype none
// ============================================================================
//  Module    : tb_exp_to_float_pipe
//  Purpose   : Self-checking bench for exp_to_float_pipe (three parameter sets).
//  Revision  : 1.0 - initial release
// ============================================================================
module tb_exp_to_float_pipe;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  exp_to_float_pipe_if #(.EXP_W(8))  bus    ();
  exp_to_float_pipe_if #(.EXP_W(8))  bus_nz ();
  exp_to_float_pipe_if #(.EXP_W(11)) bus_w  ();

  exp_to_float_pipe #(.EXP_W(8),  .BIAS(127),  .ZERO_EDGE(1)) dut    (.clk(clk), .rst(rst), .bus(bus));
  exp_to_float_pipe #(.EXP_W(8),  .BIAS(127),  .ZERO_EDGE(0)) dut_nz (.clk(clk), .rst(rst), .bus(bus_nz));
  exp_to_float_pipe #(.EXP_W(11), .BIAS(1023), .ZERO_EDGE(1)) dut_w  (.clk(clk), .rst(rst), .bus(bus_w));

  // Reference: integer -> float32 via the simulator's double-precision encoding.
  function automatic logic [31:0] int_to_f32(input int d);
    real         r;
    logic [63:0] b;
    logic [10:0] e;
    if (d == 0) return 32'h0;
    r = d;
    b = $realtobits(r);
    e = b[62:52] - 11'd896;
    return {b[63], e[7:0], b[51:29]};
  endfunction

  function automatic logic [31:0] model(input int e, input int w, input int bias, input int ze);
    if (ze != 0 && (e == 0 || e == (1 << w) - 1)) return 32'h0;
    return int_to_f32(e - bias);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.in_valid = 0;    bus.exp_in = '0;    bus.out_ready = 1;
    bus_nz.in_valid = 0; bus_nz.exp_in = '0; bus_nz.out_ready = 1;
    bus_w.in_valid = 0;  bus_w.exp_in = '0;  bus_w.out_ready = 1;
    rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
    checks++; if (bus.out_data !== 32'h0) begin errors++; $display("FAIL reset_out_data: got %h expected 00000000", bus.out_data); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
    checks++; if (bus_nz.out_valid !== 1'b0 || bus_nz.in_ready !== 1'b1) begin errors++; $display("FAIL reset_nz: got valid %b ready %b expected 0 1", bus_nz.out_valid, bus_nz.in_ready); end
    checks++; if (bus_w.out_valid !== 1'b0 || bus_w.in_ready !== 1'b1) begin errors++; $display("FAIL reset_w: got valid %b ready %b expected 0 1", bus_w.out_valid, bus_w.in_ready); end
  endtask

  task automatic test_directed();
    logic [7:0]  ins [3];
    logic [31:0] exps[3];
    ins  = '{8'd1, 8'd128, 8'd254};
    exps = '{32'hC2FC0000, 32'h3F800000, 32'h42FE0000};
    for (int i = 0; i < 5; i++) begin
      step();
      if (i < 3) begin bus.in_valid = 1; bus.exp_in = ins[i]; end
      else       begin bus.in_valid = 0; end
      @(negedge clk);
      if (i >= 2) begin
        checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== exps[i-2]) begin errors++; $display("FAIL directed_%0d: got valid %b data %h expected 1 %h", i-2, bus.out_valid, bus.out_data, exps[i-2]); end
      end else begin
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL directed_latency_%0d: got valid %b expected 0", i, bus.out_valid); end
      end
    end
    step(); step();
  endtask

  task automatic test_zero_edge();
    logic [7:0]  ins_a [3];
    logic [7:0]  ins_b [3];
    logic [31:0] exp_b [3];
    ins_a = '{8'd127, 8'd0, 8'd255};
    ins_b = '{8'd0, 8'd255, 8'd127};
    exp_b = '{32'hC2FE0000, 32'h43000000, 32'h00000000};
    for (int i = 0; i < 5; i++) begin
      step();
      if (i < 3) begin
        bus.in_valid = 1;    bus.exp_in = ins_a[i];
        bus_nz.in_valid = 1; bus_nz.exp_in = ins_b[i];
      end else begin
        bus.in_valid = 0; bus_nz.in_valid = 0;
      end
      @(negedge clk);
      if (i >= 2) begin
        checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h0) begin errors++; $display("FAIL zero_edge_on_%0d: got valid %b data %h expected 1 00000000", i-2, bus.out_valid, bus.out_data); end
        checks++; if (bus_nz.out_valid !== 1'b1 || bus_nz.out_data !== exp_b[i-2]) begin errors++; $display("FAIL zero_edge_off_%0d: got valid %b data %h expected 1 %h", i-2, bus_nz.out_valid, bus_nz.out_data, exp_b[i-2]); end
      end
    end
    step(); step();
  endtask

  task automatic test_wide();
    logic [10:0] ins [3];
    logic [31:0] exps[3];
    ins  = '{11'd1023, 11'd2046, 11'd1};
    exps = '{32'h00000000, 32'h447FC000, 32'hC47F8000};
    for (int i = 0; i < 5; i++) begin
      step();
      if (i < 3) begin bus_w.in_valid = 1; bus_w.exp_in = ins[i]; end
      else       begin bus_w.in_valid = 0; end
      @(negedge clk);
      if (i >= 2) begin
        checks++; if (bus_w.out_valid !== 1'b1 || bus_w.out_data !== exps[i-2]) begin errors++; $display("FAIL wide_%0d: got valid %b data %h expected 1 %h", i-2, bus_w.out_valid, bus_w.out_data, exps[i-2]); end
      end
    end
    step(); step();
  endtask

  task automatic test_sweep();
    logic [31:0] expv;
    bus.out_ready = 1;
    for (int i = 0; i < 258; i++) begin
      step();
      bus.in_valid = (i < 256);
      bus.exp_in   = 8'(i);
      @(negedge clk);
      checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL sweep_in_ready_%0d: got %b expected 1", i, bus.in_ready); end
      if (i >= 2) begin
        expv = model(i - 2, 8, 127, 1);
        checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== expv) begin errors++; $display("FAIL sweep_%0d: got valid %b data %h expected 1 %h", i-2, bus.out_valid, bus.out_data, expv); end
      end
    end
    step(); bus.in_valid = 0;
    step();
  endtask

  task automatic test_backpressure();
    logic [7:0]  vals[4];
    logic [31:0] expv;
    logic        acc;
    int sent = 0;
    int got  = 0;
    int cyc  = 0;
    vals = '{8'd10, 8'd20, 8'd30, 8'd40};
    step();
    bus.out_ready = 0;
    bus.in_valid  = 1;
    bus.exp_in    = vals[0];
    while ((sent < 4 || got < 4) && cyc < 40) begin
      @(negedge clk);
      if (cyc == 2 || cyc == 3) begin
        checks++; if (bus.in_ready !== 1'b0 || sent != 2) begin errors++; $display("FAIL bp_full_%0d: got in_ready %b accepted %0d expected 0 2", cyc, bus.in_ready, sent); end
        expv = model(10, 8, 127, 1);
        checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== expv) begin errors++; $display("FAIL bp_stable_%0d: got valid %b data %h expected 1 %h", cyc, bus.out_valid, bus.out_data, expv); end
      end
      if (bus.out_valid && bus.out_ready) begin
        if (got < 4) begin
          expv = model(int'(vals[got]), 8, 127, 1);
          checks++; if (bus.out_data !== expv) begin errors++; $display("FAIL bp_order_%0d: got %h expected %h", got, bus.out_data, expv); end
        end else begin
          checks++; errors++; $display("FAIL bp_extra: got %h expected no word", bus.out_data);
        end
        got++;
      end
      acc = bus.in_valid && bus.in_ready;
      step();
      if (acc) sent++;
      if (cyc == 3) bus.out_ready = 1;
      if (sent < 4) begin bus.in_valid = 1; bus.exp_in = vals[sent]; end
      else          begin bus.in_valid = 0; end
      cyc++;
    end
    checks++; if (got != 4 || sent != 4) begin errors++; $display("FAIL bp_count: got %0d out %0d in expected 4 4", got, sent); end
    bus.in_valid = 0;
    step(); step();
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL bp_drained: got valid %b expected 0", bus.out_valid); end
  endtask

  task automatic test_random();
    logic [31:0] q[$];
    logic [31:0] prev_data = '0;
    logic [31:0] expv;
    logic        prev_stall = 1'b0;
    logic        exp_ready;
    for (int cyc = 0; cyc < 420; cyc++) begin
      step();
      if (cyc < 400) begin
        bus.in_valid  = ($urandom % 4) != 0;
        bus.exp_in    = 8'($urandom);
        bus.out_ready = ($urandom % 3) != 0;
      end else begin
        bus.in_valid  = 0;
        bus.out_ready = 1;
      end
      @(negedge clk);
      if (prev_stall) begin
        checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== prev_data) begin errors++; $display("FAIL rand_hold_%0d: got valid %b data %h expected 1 %h", cyc, bus.out_valid, bus.out_data, prev_data); end
      end
      exp_ready = (q.size() < 2) || bus.out_ready;
      checks++; if (bus.in_ready !== exp_ready) begin errors++; $display("FAIL rand_in_ready_%0d: got %b expected %b", cyc, bus.in_ready, exp_ready); end
      if (bus.out_valid && bus.out_ready) begin
        if (q.size() == 0) begin
          checks++; errors++; $display("FAIL rand_unexpected_%0d: got %h expected no word", cyc, bus.out_data);
        end else begin
          expv = q.pop_front();
          checks++; if (bus.out_data !== expv) begin errors++; $display("FAIL rand_data_%0d: got %h expected %h", cyc, bus.out_data, expv); end
        end
      end
      if (bus.in_valid && bus.in_ready) q.push_back(model(int'(bus.exp_in), 8, 127, 1));
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_data  = bus.out_data;
    end
    checks++; if (q.size() != 0) begin errors++; $display("FAIL rand_lost: got %0d words pending expected 0", q.size()); end
  endtask

  task automatic test_reset_midflight();
    logic [31:0] expv;
    step();
    bus.out_ready = 0; bus.in_valid = 1; bus.exp_in = 8'd50;
    step();
    bus.exp_in = 8'd60;
    step();
    bus.in_valid = 0;
    @(negedge clk);
    checks++; if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin errors++; $display("FAIL mid_full: got ready %b valid %b expected 0 1", bus.in_ready, bus.out_valid); end
    step();
    rst = 1;
    step();
    rst = 0;
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL mid_out_valid: got %b expected 0", bus.out_valid); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL mid_in_ready: got %b expected 1", bus.in_ready); end
    checks++; if (bus.out_data !== 32'h0) begin errors++; $display("FAIL mid_out_data: got %h expected 00000000", bus.out_data); end
    bus.out_ready = 1;
    for (int i = 0; i < 5; i++) begin
      step();
      @(negedge clk);
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL mid_stale_%0d: got valid %b data %h expected 0", i, bus.out_valid, bus.out_data); end
    end
    for (int i = 0; i < 3; i++) begin
      step();
      bus.in_valid = (i == 0);
      bus.exp_in   = 8'd200;
      @(negedge clk);
    end
    expv = model(200, 8, 127, 1);
    checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== expv) begin errors++; $display("FAIL mid_resume: got valid %b data %h expected 1 %h", bus.out_valid, bus.out_data, expv); end
    step(); step();
  endtask

  initial begin
    test_reset();
    test_directed();
    test_zero_edge();
    test_wide();
    test_sweep();
    test_backpressure();
    test_random();
    test_reset_midflight();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
